// File: rtl/csr_pkg.sv
// Shared CSR addresses, op encoding, cause codes and the read-modify-write helper
// for the machine-mode CSR file.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [3:0]  IRQ_TIMER = 4'd7;
  localparam logic [3:0]  IRQ_EXT   = 4'd11;
  localparam logic [31:0] MIE_MASK  = 32'h0000_0880;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;

  function automatic logic [31:0] csr_update(input csr_op_e op, input logic [31:0] old,
                                             input logic [31:0] wdata);
    case (op)
      CSR_WRITE: return wdata;
      CSR_SET:   return old | wdata;
      CSR_CLEAR: return old & ~wdata;
      default:   return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_unit_counter64.sv
// 64-bit free-running counter; a half write replaces that cycle's increment
// and leaves the other half untouched.
module csr_unit_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt <= '0;
    else if (wr_lo) cnt[31:0]  <= wdata;
    else if (wr_hi) cnt[63:32] <= wdata;
    else if (inc)   cnt <= cnt + 64'd1;
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file beside Execute: CSR read/write, timer/external interrupt
// entry, mret return and the mcycle/minstret counters.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] pc,
  input  logic        csr_rd,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        is_mret,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic [31:0] csr_rdata,
  output logic [31:0] epc,
  output logic        epc_taken
);

  mstatus_t    mstatus_q;
  logic [31:0] mie_q, mepc_q, mcause_q, mtvec_q;
  logic        mtip_q, meip_q;
  logic [63:0] mcycle, minstret;

  logic [31:0] mip_v, irq_pend, csr_old, csr_new, vec_base, trap_vec;
  logic [3:0]  cause;
  logic        irq_take, mret_take, csr_we;
  csr_op_e     op;

  assign op       = csr_op_e'(csr_op);
  assign mip_v    = {20'b0, meip_q, 3'b0, mtip_q, 7'b0};
  assign irq_pend = mie_q & mip_v;
  assign irq_take = inst_valid & mstatus_q.mie & (|irq_pend);
  assign cause    = irq_pend[11] ? IRQ_EXT : IRQ_TIMER;
  assign mret_take = inst_valid & is_mret & ~irq_take;
  // A trapped or returning instruction never commits its CSR write.
  assign csr_we   = (op != CSR_NONE) & ~irq_take & ~mret_take;
  assign csr_new  = csr_update(op, csr_old, csr_wdata);

  assign vec_base = {mtvec_q[31:2], 2'b00};
  assign trap_vec = mtvec_q[0] ? vec_base + {26'b0, cause, 2'b00} : vec_base;

  always_comb begin
    csr_old = '0;
    case (csr_addr)
      CSR_MSTATUS:   csr_old = {24'b0, mstatus_q.mpie, 3'b0, mstatus_q.mie, 3'b0};
      CSR_MIE:       csr_old = mie_q;
      CSR_MTVEC:     csr_old = mtvec_q;
      CSR_MEPC:      csr_old = mepc_q;
      CSR_MCAUSE:    csr_old = mcause_q;
      CSR_MIP:       csr_old = mip_v;
      CSR_MCYCLE:    csr_old = mcycle[31:0];
      CSR_MCYCLEH:   csr_old = mcycle[63:32];
      CSR_MINSTRET:  csr_old = minstret[31:0];
      CSR_MINSTRETH: csr_old = minstret[63:32];
      CSR_MHARTID:   csr_old = HART_ID;
      default:       csr_old = '0;
    endcase
  end

  assign csr_rdata = csr_rd ? csr_old : '0;

  always_comb begin
    epc       = mepc_q;
    epc_taken = 1'b0;
    if (!rst) begin
      epc = '0;
    end else if (irq_take) begin
      epc       = trap_vec;
      epc_taken = 1'b1;
    end else if (mret_take) begin
      epc_taken = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_q <= '0;
      mie_q     <= '0;
      mtip_q    <= 1'b0;
      meip_q    <= 1'b0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mtvec_q   <= MTVEC_RST & ~32'h2;
    end else begin
      mtip_q <= timer_irq;
      meip_q <= ext_irq;
      if (irq_take) begin
        mepc_q         <= {pc[31:2], 2'b00};
        mcause_q       <= {1'b1, 27'b0, cause};
        mstatus_q.mpie <= mstatus_q.mie;
        mstatus_q.mie  <= 1'b0;
      end else if (mret_take) begin
        mstatus_q.mie  <= mstatus_q.mpie;
        mstatus_q.mpie <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: mstatus_q <= '{mpie: csr_new[7], mie: csr_new[3]};
          CSR_MIE:     mie_q     <= csr_new & MIE_MASK;
          CSR_MTVEC:   mtvec_q   <= csr_new & ~32'h2;
          CSR_MEPC:    mepc_q    <= {csr_new[31:2], 2'b00};
          CSR_MCAUSE:  mcause_q  <= csr_new;
          default:     ;
        endcase
      end
    end
  end

  csr_unit_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (csr_we && csr_addr == CSR_MCYCLE),
    .wr_hi (csr_we && csr_addr == CSR_MCYCLEH),
    .wdata (csr_new),
    .cnt   (mcycle)
  );

  csr_unit_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (inst_valid & ~irq_take),
    .wr_lo (csr_we && csr_addr == CSR_MINSTRET),
    .wr_hi (csr_we && csr_addr == CSR_MINSTRETH),
    .wdata (csr_new),
    .cnt   (minstret)
  );

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios plus randomized traffic
// checked against a behavioural CSR model.
module tb_csr_unit;
  import csr_pkg::*;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
  localparam logic [31:0] HART_ID   = 32'h0;

  logic        clk = 1'b0, rst = 1'b0;
  logic        inst_valid = 1'b0, csr_rd = 1'b0, is_mret = 1'b0;
  logic        timer_irq = 1'b0, ext_irq = 1'b0;
  logic [31:0] pc = '0, csr_wdata = '0;
  logic [1:0]  csr_op = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_rdata, epc;
  logic        epc_taken;

  int checks = 0;
  int errors = 0;

  csr_unit #(.MTVEC_RST(MTVEC_RST), .HART_ID(HART_ID)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc(pc), .csr_rd(csr_rd),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .is_mret(is_mret),
    .timer_irq(timer_irq), .ext_irq(ext_irq), .csr_rdata(csr_rdata), .epc(epc),
    .epc_taken(epc_taken)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit          r_ie, r_pie;
  logic [31:0] r_mie, r_mip, r_mepc, r_mcause, r_mtvec;
  logic [63:0] r_cyc, r_ins;

  function automatic void m_reset();
    r_ie = 0; r_pie = 0; r_mie = 0; r_mip = 0; r_mepc = 0; r_mcause = 0;
    r_mtvec = MTVEC_RST; r_cyc = 0; r_ins = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return (r_ie ? 32'h8 : 32'h0) | (r_pie ? 32'h80 : 32'h0);
      12'h304: return r_mie;
      12'h305: return r_mtvec;
      12'h341: return r_mepc;
      12'h342: return r_mcause;
      12'h344: return r_mip;
      12'hB00: return r_cyc[31:0];
      12'hB80: return r_cyc[63:32];
      12'hB02: return r_ins[31:0];
      12'hB82: return r_ins[63:32];
      12'hF14: return HART_ID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_irq();
    return inst_valid && r_ie && ((r_mie & r_mip) != 0);
  endfunction

  function automatic int m_cause();
    return ((r_mie & r_mip & 32'h800) != 0) ? 11 : 7;
  endfunction

  function automatic logic [31:0] m_epc();
    if (!m_irq()) return r_mepc;
    return (r_mtvec & ~32'h3) + ((r_mtvec & 32'h3) == 1 ? 32'(m_cause() * 4) : 32'h0);
  endfunction

  function automatic bit m_taken();
    return m_irq() || (inst_valid && is_mret);
  endfunction

  function automatic logic [31:0] m_rdata();
    return csr_rd ? m_read(csr_addr) : 32'h0;
  endfunction

  function automatic void m_commit();
    bit irq, mret, we;
    logic [31:0] old, nv;
    logic [63:0] cyc_n, ins_n;
    irq  = m_irq();
    mret = !irq && inst_valid && is_mret;
    old  = m_read(csr_addr);
    nv   = (csr_op == 1) ? csr_wdata : (csr_op == 2) ? (old | csr_wdata) : (old & ~csr_wdata);
    we   = (csr_op != 0) && !irq && !mret;
    cyc_n = r_cyc + 1;
    ins_n = r_ins + ((inst_valid && !irq) ? 1 : 0);
    if (we && csr_addr == 12'hB00) cyc_n = {r_cyc[63:32], nv};
    if (we && csr_addr == 12'hB80) cyc_n = {nv, r_cyc[31:0]};
    if (we && csr_addr == 12'hB02) ins_n = {r_ins[63:32], nv};
    if (we && csr_addr == 12'hB82) ins_n = {nv, r_ins[31:0]};
    if (irq) begin
      r_mepc = pc & ~32'h3;
      r_mcause = 32'h8000_0000 | 32'(m_cause());
      r_pie = r_ie; r_ie = 0;
    end else if (mret) begin
      r_ie = r_pie; r_pie = 1;
    end else if (we) begin
      case (csr_addr)
        12'h300: begin r_ie = nv[3]; r_pie = nv[7]; end
        12'h304: r_mie = nv & 32'h880;
        12'h305: r_mtvec = nv & ~32'h2;
        12'h341: r_mepc = nv & ~32'h3;
        12'h342: r_mcause = nv;
        default: ;
      endcase
    end
    r_mip = (ext_irq ? 32'h800 : 32'h0) | (timer_irq ? 32'h80 : 32'h0);
    r_cyc = cyc_n;
    r_ins = ins_n;
  endfunction

  task automatic drv(input logic v, input logic [31:0] p, input logic rd, input logic [1:0] op,
                     input logic [11:0] a, input logic [31:0] wd, input logic mr);
    inst_valid = v; pc = p; csr_rd = rd; csr_op = op; csr_addr = a; csr_wdata = wd; is_mret = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    m_commit();
    #1;
  endtask

  task automatic finish_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    drv(0, 0, 0, 0, 0, 0, 0);
    timer_irq = 0; ext_irq = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drv(1, 32'h40, 1, 0, 12'h300, 0, 1);
    #1;
    checks++; if (epc_taken !== 1'b0 || epc !== 32'h0) begin errors++;
      $display("FAIL rst_epc got taken=%b epc=%h need 0/0", epc_taken, epc); end
    finish_reset();
    drv(1, 0, 1, 0, 12'h300, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rst_mstatus got %h need 0", csr_rdata); end
    checks++; if (epc_taken !== 1'b0) begin errors++; $display("FAIL rst_taken got %b need 0", epc_taken); end
    tick();
    drv(1, 0, 1, 0, 12'h305, 0, 0); #4;
    checks++; if (csr_rdata !== MTVEC_RST) begin errors++; $display("FAIL rst_mtvec got %h need %h", csr_rdata, MTVEC_RST); end
    tick();
    drv(1, 0, 1, 0, 12'h341, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rst_mepc got %h need 0", csr_rdata); end
    tick();
    drv(0, 0, 1, 0, 12'hF14, 0, 0); #4;
    checks++; if (csr_rdata !== HART_ID) begin errors++; $display("FAIL mhartid got %h need %h", csr_rdata, HART_ID); end
    tick();
  endtask

  task automatic test_timer_trap();
    drv(1, 0, 0, 2'b01, 12'h305, 32'h0000_0101, 0); tick();
    drv(1, 0, 0, 2'b10, 12'h304, 32'h80, 0); tick();
    drv(1, 0, 0, 2'b10, 12'h300, 32'h8, 0); tick();
    timer_irq = 1;
    drv(1, 32'h3C, 0, 0, 0, 0, 0); #4;
    checks++; if (epc_taken !== 1'b0) begin errors++; $display("FAIL mip_latency got taken=%b need 0", epc_taken); end
    tick();
    drv(1, 32'h40, 0, 0, 0, 0, 0); #4;
    checks++; if (epc_taken !== 1'b1 || epc !== 32'h11C) begin errors++;
      $display("FAIL timer_trap got taken=%b epc=%h need 1/0000011c", epc_taken, epc); end
    tick();
    timer_irq = 0;
    drv(1, 32'h44, 1, 0, 12'h341, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h40) begin errors++; $display("FAIL trap_mepc got %h need 00000040", csr_rdata); end
    tick();
    drv(1, 32'h48, 1, 0, 12'h342, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h8000_0007) begin errors++; $display("FAIL trap_mcause got %h need 80000007", csr_rdata); end
    tick();
    drv(1, 32'h4C, 1, 0, 12'h300, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h80) begin errors++; $display("FAIL trap_mstatus got %h need 00000080", csr_rdata); end
    tick();
  endtask

  task automatic test_mret();
    drv(1, 32'h100, 0, 0, 0, 0, 1); #4;
    checks++; if (epc_taken !== 1'b1 || epc !== 32'h40) begin errors++;
      $display("FAIL mret_epc got taken=%b epc=%h need 1/00000040", epc_taken, epc); end
    tick();
    drv(1, 32'h40, 1, 0, 12'h300, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h88) begin errors++; $display("FAIL mret_mstatus got %h need 00000088", csr_rdata); end
    tick();
  endtask

  task automatic test_both_irq();
    drv(1, 32'h44, 0, 2'b10, 12'h304, 32'h800, 0); tick();
    timer_irq = 1; ext_irq = 1;
    drv(0, 0, 0, 0, 0, 0, 0); tick();
    drv(1, 32'h80, 0, 0, 0, 0, 0); #4;
    checks++; if (epc_taken !== 1'b1 || epc !== 32'h12C) begin errors++;
      $display("FAIL ext_prio_epc got taken=%b epc=%h need 1/0000012c", epc_taken, epc); end
    tick();
    timer_irq = 0; ext_irq = 0;
    drv(1, 32'h100, 1, 0, 12'h342, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h8000_000B) begin errors++; $display("FAIL ext_mcause got %h need 8000000b", csr_rdata); end
    tick();
    drv(1, 32'h104, 0, 0, 0, 0, 1); #4;
    checks++; if (epc_taken !== 1'b1 || epc !== 32'h80) begin errors++;
      $display("FAIL mret2_epc got taken=%b epc=%h need 1/00000080", epc_taken, epc); end
    tick();
  endtask

  task automatic test_write_vs_irq();
    logic [31:0] ins_before;
    timer_irq = 1;
    drv(0, 0, 1, 0, 12'hB02, 0, 0); #4;
    checks++; if (csr_rdata !== m_rdata()) begin errors++; $display("FAIL minstret_pre got %h need %h", csr_rdata, m_rdata()); end
    ins_before = r_ins[31:0];
    tick();
    drv(1, 32'h300, 0, 2'b10, 12'h300, 32'h8, 0); #4;
    checks++; if (epc_taken !== 1'b1 || epc !== 32'h11C) begin errors++;
      $display("FAIL wr_irq_trap got taken=%b epc=%h need 1/0000011c", epc_taken, epc); end
    tick();
    timer_irq = 0;
    drv(0, 0, 1, 0, 12'hB02, 0, 0); #4;
    checks++; if (csr_rdata !== ins_before) begin errors++; $display("FAIL minstret_squash got %h need %h", csr_rdata, ins_before); end
    tick();
    drv(0, 0, 1, 0, 12'h300, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h80) begin errors++; $display("FAIL wr_dropped got %h need 00000080", csr_rdata); end
    tick();
    drv(1, 32'h8, 0, 0, 0, 0, 1); #4;
    checks++; if (epc_taken !== 1'b1 || epc !== 32'h300) begin errors++;
      $display("FAIL mret3_epc got taken=%b epc=%h need 1/00000300", epc_taken, epc); end
    tick();
  endtask

  task automatic test_counters();
    drv(1, 0, 0, 2'b01, 12'h341, 32'h123, 0); tick();
    drv(1, 0, 1, 0, 12'h341, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h120) begin errors++; $display("FAIL mepc_mask got %h need 00000120", csr_rdata); end
    tick();
    drv(1, 0, 0, 2'b01, 12'hB80, 32'h0, 0); tick();
    drv(1, 0, 0, 2'b01, 12'hB00, 32'hFFFF_FFFF, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 1, 0, 12'hB00, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mcycle_carry_lo got %h need 0", csr_rdata); end
    tick();
    drv(0, 0, 1, 0, 12'hB80, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h1) begin errors++; $display("FAIL mcycle_carry_hi got %h need 1", csr_rdata); end
    tick();
    drv(1, 0, 0, 2'b01, 12'hB82, 32'hFFFF_FFFF, 0); tick();
    drv(1, 0, 0, 2'b01, 12'hB02, 32'hFFFF_FFFF, 0); tick();
    drv(1, 0, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 1, 0, 12'hB82, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL minstret_wrap got %h need 0", csr_rdata); end
    tick();
    drv(1, 0, 0, 2'b01, 12'h344, 32'hFFFF_FFFF, 0); tick();
    drv(0, 0, 1, 0, 12'h344, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mip_readonly got %h need 0", csr_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    drv(1, 0, 0, 2'b10, 12'h304, 32'h80, 0); tick();
    drv(1, 0, 0, 2'b10, 12'h300, 32'h8, 0); tick();
    timer_irq = 1;
    drv(0, 0, 0, 0, 0, 0, 0); tick();
    drv(1, 32'h500, 0, 2'b01, 12'h341, 32'h777, 0); #2;
    checks++; if (epc_taken !== 1'b1) begin errors++; $display("FAIL pre_rst_trap got %b need 1", epc_taken); end
    rst = 1'b0; #1;
    checks++; if (epc_taken !== 1'b0 || epc !== 32'h0) begin errors++;
      $display("FAIL rst_mid got taken=%b epc=%h need 0/0", epc_taken, epc); end
    finish_reset();
    drv(0, 0, 1, 0, 12'h341, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_mepc got %h need 0", csr_rdata); end
    tick();
    drv(0, 0, 1, 0, 12'h300, 0, 0); #4;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_mstatus got %h need 0", csr_rdata); end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] addrs [14];
    logic        v, mr;
    logic [1:0]  op;
    addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'hB00,
              12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h300, 12'h304};
    for (int i = 0; i < 600; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      op = v ? 2'($urandom_range(0, 3)) : 2'b00;
      mr = v && (op == 0) && ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) timer_irq = ~timer_irq;
      if ($urandom_range(0, 9) == 0) ext_irq = ~ext_irq;
      drv(v, $urandom, 1'($urandom_range(0, 1)), op, addrs[$urandom_range(0, 13)], $urandom, mr);
      #4;
      checks++; if (csr_rdata !== m_rdata()) begin errors++;
        $display("FAIL rand_rdata[%0d] addr=%h got %h need %h", i, csr_addr, csr_rdata, m_rdata()); end
      checks++; if (epc_taken !== m_taken() || epc !== m_epc()) begin errors++;
        $display("FAIL rand_epc[%0d] got %b/%h need %b/%h", i, epc_taken, epc, m_taken(), m_epc()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_timer_trap();
    test_mret();
    test_both_irq();
    test_write_vs_irq();
    test_counters();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
